// File: rtl/bldc_pkg.sv
// Shared Hall/commutation tables for the BLDC emulator and the MAIN_1 commutation logic.
package bldc_pkg;

  localparam int SECTOR_NUM = 6;

  typedef logic [2:0] sector_t;

  // Hall pattern {H3,H2,H1} shown while the rotor sits in a sector.
  function automatic logic [2:0] hall_of(input sector_t s);
    case (s)
      3'd0:    return 3'b001;
      3'd1:    return 3'b101;
      3'd2:    return 3'b100;
      3'd3:    return 3'b110;
      3'd4:    return 3'b010;
      3'd5:    return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // Gate pair that must be active in a sector, as a {A,B,C,AA,BB,CC} mask.
  function automatic logic [5:0] gate_exp(input sector_t s);
    case (s)
      3'd0:    return 6'b100_010;  // A,  BB
      3'd1:    return 6'b100_001;  // A,  CC
      3'd2:    return 6'b010_001;  // B,  CC
      3'd3:    return 6'b010_100;  // B,  AA
      3'd4:    return 6'b001_100;  // C,  AA
      3'd5:    return 6'b001_010;  // C,  BB
      default: return 6'b000_000;
    endcase
  endfunction

  // Neighbouring sector in the requested direction, wrapping 5<->0.
  function automatic sector_t sector_next(input sector_t s, input logic dir);
    if (!dir) return (s == sector_t'(SECTOR_NUM - 1)) ? sector_t'(0) : s + sector_t'(1);
    else      return (s == sector_t'(0)) ? sector_t'(SECTOR_NUM - 1) : s - sector_t'(1);
  endfunction

endpackage

// File: rtl/bldc_shoot_det.sv
// Run-length detector for one bridge leg: flags when high and low side
// have been on together for SHOOT_CLKS consecutive cycles.
module bldc_shoot_det
  import bldc_pkg::*;
#(
  parameter int SHOOT_CLKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hi,
  input  logic lo,
  output logic hit
);

  localparam int RUN_W = $clog2(SHOOT_CLKS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SHOOT_CLKS - 1);

  logic [RUN_W-1:0] run;

  // The cycle that completes the run raises hit, so the fault lands on that edge.
  assign hit = hi & lo & (run >= RUN_MAX);

  // Count overlap cycles, parking at RUN_MAX; any gap restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= '0;
    end else if (hi & lo) begin
      if (run != RUN_MAX) run <= run + RUN_W'(1);
    end else begin
      run <= '0;
    end
  end

endmodule

// File: rtl/bldc_hall_emulator.sv
// BLDC motor / Hall sensor stand-in: steps the 6-sector Hall sequence at a
// programmable rate and audits the gate drives for shoot-through and for
// a wrong commutation pattern per sector.
module bldc_hall_emulator
  import bldc_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int CNT_W      = 8,
  parameter int SHOOT_CLKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [DIV_W-1:0] step_div,
  input  logic             clr_fault,
  input  logic             a,
  input  logic             aa,
  input  logic             b,
  input  logic             bb,
  input  logic             c,
  input  logic             cc,
  output logic             h1,
  output logic             h2,
  output logic             h3,
  output logic [2:0]       sector,
  output logic             step,
  output logic             fault_shoot,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [DIV_W-1:0] cnt;
  logic [5:0]       seen;
  logic [5:0]       gates;
  logic [2:0]       hit;
  sector_t          sector_nx;
  logic             active;
  logic             at_last;
  logic             over_run;
  logic             step_now;
  logic             mis_now;

  // STEP_DIV of zero behaves exactly like EN low: everything holds.
  assign active    = en && (step_div != '0);
  assign at_last   = (cnt == step_div - DIV_W'(1));
  assign over_run  = (cnt >  step_div - DIV_W'(1));
  assign step_now  = active && at_last;
  assign sector_nx = sector_next(sector, dir);
  assign gates     = {a, b, c, aa, bb, cc};
  // The mask as it stood before this edge covers the dwell being left.
  assign mis_now   = step_now && (seen != gate_exp(sector));

  bldc_shoot_det #(.SHOOT_CLKS(SHOOT_CLKS)) u_shoot_a (.clk(clk), .rst_n(rst_n), .hi(a), .lo(aa), .hit(hit[0]));
  bldc_shoot_det #(.SHOOT_CLKS(SHOOT_CLKS)) u_shoot_b (.clk(clk), .rst_n(rst_n), .hi(b), .lo(bb), .hit(hit[1]));
  bldc_shoot_det #(.SHOOT_CLKS(SHOOT_CLKS)) u_shoot_c (.clk(clk), .rst_n(rst_n), .hi(c), .lo(cc), .hit(hit[2]));

  // Dwell counter and sector/Hall register; Hall loads straight from the next sector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sector       <= '0;
      {h3, h2, h1} <= hall_of(sector_t'(0));
      step         <= 1'b0;
    end else begin
      step <= step_now;
      if (active) begin
        // A shrunken STEP_DIV below the current count just restarts the dwell.
        if (at_last || over_run) cnt <= '0;
        else                     cnt <= cnt + DIV_W'(1);
        if (at_last) begin
          sector       <= sector_nx;
          {h3, h2, h1} <= hall_of(sector_nx);
        end
      end
    end
  end

  // Accumulate every gate seen during the dwell so PWM-chopped drives still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        seen <= '0;
    else if (step_now) seen <= gates;
    else               seen <= seen | gates;
  end

  // Saturating wrong-pattern counter; a fresh mismatch beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (mis_now) begin
      if (clr_fault)               mismatch_cnt <= CNT_W'(1);
      else if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end else if (clr_fault) begin
      mismatch_cnt <= '0;
    end
  end

  // Sticky shoot-through flag; a fresh detection beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_shoot <= 1'b0;
    else if (|hit)      fault_shoot <= 1'b1;
    else if (clr_fault) fault_shoot <= 1'b0;
  end

endmodule
